// File: rtl/abc_arbiter.sv
// Round-robin arbiter sharing one abc datapath among NREQ requesters, with ID-tagged responses.
// Optional ABC_ARB_STATS_EN adds a saturating 16-bit grant counter output (grant_cnt).
module abc_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2,
    parameter int unsigned LAT  = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] op_a,
    input  logic [NREQ-1:0] op_b,
    output logic [NREQ-1:0] gnt,
    output logic            abc_data1,
    output logic            abc_data2,
    input  logic            abc_out,
`ifdef ABC_ARB_STATS_EN
    output logic [15:0]     grant_cnt,
`endif
    output logic            rsp_valid,
    output logic [IDW-1:0]  rsp_id,
    output logic            rsp_data
);

    localparam int unsigned STAGES = LAT + 1;

    logic [NREQ-1:0]            gnt_q, gnt_d;
    logic                       d1_q, d1_d;
    logic                       d2_q, d2_d;
    logic [IDW-1:0]             ptr_q, ptr_d;
    logic [STAGES-1:0]          vld_q;
    logic [STAGES-1:0][IDW-1:0] id_q;

    logic [NREQ-1:0] elig_c;
    logic            found_c;
    logic [IDW-1:0]  win_c;
    logic [IDW-1:0]  cand_c;

    // Last cycle's grant doubles as the mask, so a winner sits out exactly one edge.
    assign elig_c = req & ~gnt_q;

    // Rotating search starting just after the last winner.
    always_comb begin
        found_c = 1'b0;
        win_c   = '0;
        cand_c  = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand_c = IDW'((32'(ptr_q) + i) % NREQ);
            if (!found_c && elig_c[cand_c]) begin
                found_c = 1'b1;
                win_c   = cand_c;
            end
        end
    end

    always_comb begin
        gnt_d = '0;
        d1_d  = 1'b0;
        d2_d  = 1'b0;
        ptr_d = ptr_q;
        if (found_c) begin
            gnt_d[win_c] = 1'b1;
            d1_d         = op_a[win_c];
            d2_d         = op_b[win_c];
            ptr_d        = win_c;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gnt_q <= '0;
            d1_q  <= 1'b0;
            d2_q  <= 1'b0;
            ptr_q <= IDW'(NREQ - 1);
        end else begin
            gnt_q <= gnt_d;
            d1_q  <= d1_d;
            d2_q  <= d2_d;
            ptr_q <= ptr_d;
        end
    end

    // Valid/ID tracker, aligned with the datapath latency; never stalls.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            id_q  <= '0;
        end else begin
            vld_q <= {vld_q[STAGES-2:0], found_c};
            id_q  <= {id_q[STAGES-2:0], win_c};
        end
    end

`ifdef ABC_ARB_STATS_EN
    logic [15:0] grant_cnt_q, grant_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        if (found_c && (grant_cnt_q != 16'hFFFF)) begin
            grant_cnt_d = grant_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_cnt_q <= 16'd0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign grant_cnt = grant_cnt_q;
`endif

    assign gnt       = gnt_q;
    assign abc_data1 = d1_q;
    assign abc_data2 = d2_q;
    assign rsp_valid = vld_q[STAGES-1];
    assign rsp_id    = id_q[STAGES-1];
    assign rsp_data  = abc_out;

endmodule

// File: tb/tb_abc_arbiter.sv
// Scoreboard bench for abc_arbiter: directed grant vectors, a behavioural abc datapath,
// and a decoupled response monitor.
module tb_abc_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;
    localparam int          LAT  = 2;

    logic            clock = 1'b0;
    logic            reset;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] op_a;
    logic [NREQ-1:0] op_b;
    logic [NREQ-1:0] gnt;
    logic            abc_data1;
    logic            abc_data2;
    logic            abc_out;
    logic            rsp_valid;
    logic [IDW-1:0]  rsp_id;
    logic            rsp_data;
`ifdef ABC_ARB_STATS_EN
    logic [15:0]     grant_cnt;
`endif

    abc_arbiter #(.NREQ(NREQ), .IDW(IDW), .LAT(LAT)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .gnt       (gnt),
        .abc_data1 (abc_data1),
        .abc_data2 (abc_data2),
        .abc_out   (abc_out),
`ifdef ABC_ARB_STATS_EN
        .grant_cnt (grant_cnt),
`endif
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    always #5 clock = ~clock;

    // Behavioural abc: register operands, OR, register result.
    logic r1_q, r2_q, out_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r1_q  <= 1'b0;
            r2_q  <= 1'b0;
            out_q <= 1'b0;
        end else begin
            r1_q  <= abc_data1;
            r2_q  <= abc_data2;
            out_q <= r1_q | r2_q;
        end
    end
    assign abc_out = out_q;

    typedef struct {
        logic [IDW-1:0] id;
        logic           data;
        int             cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b1;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor: every valid response must match the oldest outstanding grant.
    always @(negedge clock) begin
        if (mon_en && !reset && rsp_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got id=%0d data=%0b cyc=%0d with no outstanding grant",
                         rsp_id, rsp_data, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (rsp_id !== e.id || rsp_data !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL rsp: got id=%0d data=%0b cyc=%0d expected id=%0d data=%0b cyc=%0d",
                             rsp_id, rsp_data, cyc, e.id, e.data, e.cyc);
                end
            end
        end
    end

    // One clock of stimulus with the hand-computed grant and operand outputs.
    task automatic step(input logic [3:0] r, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] eg, input logic e1, input logic e2);
        exp_t e;
        int   id;
        @(negedge clock);
        req  = r;
        op_a = a;
        op_b = b;
        @(posedge clock);
        #1;
        check("gnt", 32'(gnt), 32'(eg));
        check("abc_data", 32'({abc_data1, abc_data2}), 32'({e1, e2}));
        if (eg != 4'b0000) begin
            id = 0;
            for (int i = 0; i < 4; i++) if (eg[i]) id = i;
            e.id   = IDW'(id);
            e.data = e1 | e2;
            e.cyc  = cyc + LAT;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        op_a  = '0;
        op_b  = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_gnt", 32'(gnt), 32'h0);
        check("reset_abc_data", 32'({abc_data1, abc_data2}), 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_id", 32'(rsp_id), 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
            check("idle_rsp_valid", 32'(rsp_valid), 32'h0);
        end

        // All requesting: rotate 0,1,2,3,0
        step(4'b1111, 4'b0101, 4'b0000, 4'b0001, 1'b1, 1'b0);
        step(4'b1111, 4'b0101, 4'b0000, 4'b0010, 1'b0, 1'b0);
        step(4'b1111, 4'b0101, 4'b0000, 4'b0100, 1'b1, 1'b0);
        step(4'b1111, 4'b0101, 4'b0000, 4'b1000, 1'b0, 1'b0);
        step(4'b1111, 4'b0101, 4'b0000, 4'b0001, 1'b1, 1'b0);
        idle(3);

        // Single continuous requester: every other cycle
        for (int i = 0; i < 3; i++) begin
            step(4'b0100, 4'b0000, 4'b0100, 4'b0100, 1'b0, 1'b1);
            step(4'b0100, 4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b0);
        end
        idle(3);

        // Async reset while a response is being presented
        step(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0);
        idle(2);
        check("rsp_valid_before_reset", 32'(rsp_valid), 32'h1);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("rsp_valid_async_clear", 32'(rsp_valid), 32'h0);
        sb.delete();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Grant to 1, reset one cycle later, no stale response afterwards
        step(4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b0);
        @(negedge clock);
        req = 4'b0000;
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("rsp_valid_in_reset", 32'(rsp_valid), 32'h0);
        check("gnt_in_reset", 32'(gnt), 32'h0);
        sb.delete();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        step(4'b0011, 4'b0010, 4'b0000, 4'b0001, 1'b0, 1'b0);
        idle(4);

        // Requesters 1 and 3, pointer wrap back to 0
        step(4'b1010, 4'b0010, 4'b1000, 4'b0010, 1'b1, 1'b0);
        step(4'b1000, 4'b0010, 4'b1000, 4'b1000, 1'b0, 1'b1);
        step(4'b0011, 4'b0001, 4'b0010, 4'b0001, 1'b1, 1'b0);
        idle(4);

        check("sb_drained", 32'(sb.size()), 32'h0);

`ifdef ABC_ARB_STATS_EN
        mon_en = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("grant_cnt_reset0", 32'(grant_cnt), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        req   = 4'b1111;
        repeat (70000) @(posedge clock);
        #1;
        check("grant_cnt_sat", 32'(grant_cnt), 32'hFFFF);
        repeat (5) @(posedge clock);
        #1;
        check("grant_cnt_hold", 32'(grant_cnt), 32'hFFFF);
        reset = 1'b1;
        #1;
        check("grant_cnt_reset", 32'(grant_cnt), 32'h0);
        req = 4'b0000;
        @(negedge clock);
        reset = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
